// File: rtl/alu16_issue_if.sv
// Request/response/ALU-control bundle for the alu16_issue stage.
// The slave modport is the stage's own view; master is the environment side.
interface alu16_issue_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_func;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [1:0]     alu_op;
    logic           alu_binv;
    logic           alu_cin;
    logic [W-1:0]   alu_r;

    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic           out_err;
    logic           out_zero;
    logic           out_neg;
    logic           out_ovf;

    modport slave (
        input  in_valid, in_func, in_a, in_b, alu_r, out_ready,
        output in_ready, alu_a, alu_b, alu_op, alu_binv, alu_cin,
               out_valid, out_result, out_err, out_zero, out_neg, out_ovf
    );

    modport master (
        output in_valid, in_func, in_a, in_b, alu_r, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, alu_binv, alu_cin,
               out_valid, out_result, out_err, out_zero, out_neg, out_ovf
    );
endinterface

// File: rtl/alu16_issue.sv
// Issue/capture stage around the bit-sliced ALU: accept, settle, capture, drain.
// Define ALU16_FLAGS_EN to build the zero/negative/overflow flag registers.
module alu16_issue #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    alu16_issue_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b011;
    localparam logic [2:0] F_SLT = 3'b100;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_LESS = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;

    state_t       state_q, state_d;
    logic         settle_q, settle_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic         binv_q, binv_d;
    logic         cin_q, cin_d;
    logic         err_q, err_d;
    logic         valid_q, valid_d;
    logic [W-1:0] result_q, result_d;
    logic         out_err_q, out_err_d;

    logic [1:0]   dec_op;
    logic         dec_binv;
    logic         dec_cin;
    logic         dec_err;
    logic         accept;
    logic         capture;
    logic [W-1:0] cap_result;

    always_comb begin
        dec_op   = OP_OR;
        dec_binv = 1'b0;
        dec_cin  = 1'b0;
        dec_err  = 1'b0;
        case (bus.in_func)
            F_AND: dec_op = OP_AND;
            F_OR:  dec_op = OP_OR;
            F_ADD: dec_op = OP_ADD;
            F_SUB: begin
                dec_op   = OP_ADD;
                dec_binv = 1'b1;
                dec_cin  = 1'b1;
            end
            F_SLT: begin
                dec_op   = OP_LESS;
                dec_binv = 1'b1;
                dec_cin  = 1'b1;
            end
            default: dec_err = 1'b1;
        endcase
    end

    // EXEC spans the settle cycle plus the capture cycle, so the capture
    // edge lands two edges after accept.
    assign accept     = (state_q == S_IDLE) && bus.in_valid;
    assign capture    = (state_q == S_EXEC) && !settle_q;
    assign cap_result = err_q ? '0 : bus.alu_r;

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        binv_d    = binv_q;
        cin_d     = cin_q;
        err_d     = err_q;
        valid_d   = valid_q;
        result_d  = result_q;
        out_err_d = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.in_a;
                    b_d      = bus.in_b;
                    op_d     = dec_op;
                    binv_d   = dec_binv;
                    cin_d    = dec_cin;
                    err_d    = dec_err;
                    settle_d = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (settle_q) begin
                    settle_d = 1'b0;
                end else begin
                    result_d  = cap_result;
                    out_err_d = err_q;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            settle_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_OR;
            binv_q    <= 1'b0;
            cin_q     <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            binv_q    <= binv_d;
            cin_q     <= cin_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            out_err_q <= out_err_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_binv   = binv_q;
    assign bus.alu_cin    = cin_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_err    = out_err_q;

`ifdef ALU16_FLAGS_EN
    logic [2:0] func_q, func_d;
    logic       zero_q, zero_d;
    logic       neg_q, neg_d;
    logic       ovf_q, ovf_d;

    // Overflow is judged against the operands actually held on alu_a/alu_b.
    always_comb begin
        func_d = func_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (accept) begin
            func_d = bus.in_func;
        end
        if (capture) begin
            zero_d = (cap_result == '0);
            neg_d  = cap_result[W-1];
            ovf_d  = 1'b0;
            if (func_q == F_ADD) begin
                ovf_d = (a_q[W-1] == b_q[W-1]) && (cap_result[W-1] != a_q[W-1]);
            end else if (func_q == F_SUB) begin
                ovf_d = (a_q[W-1] != b_q[W-1]) && (cap_result[W-1] != a_q[W-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            func_q <= F_AND;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            func_q <= func_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_zero = zero_q;
    assign bus.out_neg  = neg_q;
    assign bus.out_ovf  = ovf_q;
`else
    assign bus.out_zero = 1'b0;
    assign bus.out_neg  = 1'b0;
    assign bus.out_ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_alu16_issue.sv
// Directed plus randomized bench for alu16_issue with a behavioural slice-array
// stand-in driving alu_r and a function-level reference for expected results.
module tb_alu16_issue;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu16_issue_if #(.W(W)) bus ();

    alu16_issue #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the external slice array: responds to whatever controls it sees.
    logic [W-1:0] stub_bb;
    logic [W-1:0] stub_sum;
    logic         stub_ov;
    logic         stub_less;

    always_comb begin
        bus.alu_r = '0;
        stub_bb   = bus.alu_binv ? ~bus.alu_b : bus.alu_b;
        stub_sum  = bus.alu_a + stub_bb + {{(W-1){1'b0}}, bus.alu_cin};
        stub_ov   = (bus.alu_a[W-1] == stub_bb[W-1]) && (stub_sum[W-1] != bus.alu_a[W-1]);
        stub_less = stub_sum[W-1] ^ stub_ov;
        case (bus.alu_op)
            2'b00:   bus.alu_r = bus.alu_a | stub_bb;
            2'b01:   bus.alu_r = {{(W-1){1'b0}}, stub_less};
            2'b10:   bus.alu_r = stub_sum;
            default: bus.alu_r = bus.alu_a & stub_bb;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input string nm);
        logic [1:0]   e_op;
        logic         e_binv, e_cin, e_err;
        logic [W-1:0] e_res;
        logic         e_zero, e_neg, e_ovf;

        e_op = 2'b00; e_binv = 1'b0; e_cin = 1'b0; e_err = 1'b0; e_res = '0;
        case (f)
            3'd0: begin e_op = 2'b11; e_res = a & b; end
            3'd1: begin e_op = 2'b00; e_res = a | b; end
            3'd2: begin e_op = 2'b10; e_res = a + b; end
            3'd3: begin e_op = 2'b10; e_binv = 1'b1; e_cin = 1'b1; e_res = a - b; end
            3'd4: begin
                e_op = 2'b01; e_binv = 1'b1; e_cin = 1'b1;
                e_res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            end
            default: e_err = 1'b1;
        endcase
        e_ovf = 1'b0;
`ifdef ALU16_FLAGS_EN
        e_zero = (e_res == '0);
        e_neg  = e_res[W-1];
        if (f == 3'd2) e_ovf = (a[W-1] == b[W-1]) && (e_res[W-1] != a[W-1]);
        if (f == 3'd3) e_ovf = (a[W-1] != b[W-1]) && (e_res[W-1] != a[W-1]);
`else
        e_zero = 1'b0;
        e_neg  = 1'b0;
`endif

        chk({nm, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.in_func   = f;
        bus.in_a      = a;
        bus.in_b      = b;
        tick();                                  // accept edge N
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        chk({nm, ".alu_a"},    32'(bus.alu_a),    32'(a));
        chk({nm, ".alu_b"},    32'(bus.alu_b),    32'(b));
        chk({nm, ".alu_op"},   32'(bus.alu_op),   32'(e_op));
        chk({nm, ".alu_binv"}, 32'(bus.alu_binv), 32'(e_binv));
        chk({nm, ".alu_cin"},  32'(bus.alu_cin),  32'(e_cin));
        chk({nm, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        chk({nm, ".valid_n1"}, 32'(bus.out_valid), 32'd0);
        tick();                                  // N+1: settle
        chk({nm, ".valid_n2"}, 32'(bus.out_valid), 32'd0);
        tick();                                  // N+2: capture
        chk({nm, ".valid"},  32'(bus.out_valid),  32'd1);
        chk({nm, ".result"}, 32'(bus.out_result), 32'(e_res));
        chk({nm, ".err"},    32'(bus.out_err),    32'(e_err));
        chk({nm, ".zero"},   32'(bus.out_zero),   32'(e_zero));
        chk({nm, ".neg"},    32'(bus.out_neg),    32'(e_neg));
        chk({nm, ".ovf"},    32'(bus.out_ovf),    32'(e_ovf));
        chk({nm, ".alu_a_held"}, 32'(bus.alu_a), 32'(a));
        $display("[TB] %s func=%0d a=%h b=%h result=%h err=%b zero=%b neg=%b ovf=%b hold=%0d",
                 nm, f, a, b, bus.out_result, bus.out_err, bus.out_zero, bus.out_neg,
                 bus.out_ovf, hold);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                tick();
                chk({nm, ".hold_valid"},  32'(bus.out_valid),  32'd1);
                chk({nm, ".hold_result"}, 32'(bus.out_result), 32'(e_res));
                chk({nm, ".hold_ready"},  32'(bus.in_ready),   32'd0);
            end
            bus.out_ready = 1'b1;
        end
        tick();                                  // drain edge
        chk({nm, ".drained_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, ".drained_ready"}, 32'(bus.in_ready),  32'd1);
        chk({nm, ".result_kept"},   32'(bus.out_result), 32'(e_res));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_func   = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("reset.in_ready",  32'(bus.in_ready),   32'd1);
        chk("reset.out_valid", 32'(bus.out_valid),  32'd0);
        chk("reset.result",    32'(bus.out_result), 32'd0);
        chk("reset.err",       32'(bus.out_err),    32'd0);
        chk("reset.flags",     32'({bus.out_zero, bus.out_neg, bus.out_ovf}), 32'd0);
        chk("reset.alu_a",     32'(bus.alu_a),      32'd0);
        chk("reset.alu_b",     32'(bus.alu_b),      32'd0);
        chk("reset.alu_ctl",   32'({bus.alu_op, bus.alu_binv, bus.alu_cin}), 32'd0);
        reset = 1'b0;
        tick();

        // Abort an ADD mid-EXEC with an asynchronous reset.
        bus.in_valid = 1'b1;
        bus.in_func  = 3'd2;
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h0101;
        tick();
        bus.in_valid = 1'b0;
        chk("abort.alu_op_before", 32'(bus.alu_op), 32'd2);
        reset = 1'b1;
        #1;
        chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort.alu_a",     32'(bus.alu_a),     32'd0);
        chk("abort.alu_b",     32'(bus.alu_b),     32'd0);
        chk("abort.alu_op",    32'(bus.alu_op),    32'd0);
        tick();
        reset = 1'b0;
        chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort.no_valid", 32'(bus.out_valid), 32'd0);
        end

        // Directed cases from the boundary list.
        issue(3'd2, 16'h7FFF, 16'h0001, 0, "add_ovf");
        issue(3'd3, 16'h0005, 16'h0005, 0, "sub_zero");
        issue(3'd4, 16'hFFFE, 16'h0003, 0, "slt_lt");
        issue(3'd4, 16'h0003, 16'hFFFE, 0, "slt_ge");
        issue(3'd0, 16'hF0F0, 16'h3C3C, 5, "and_bp");
        issue(3'd6, 16'h1234, 16'h0F0F, 0, "illegal");
        issue(3'd1, 16'h1200, 16'h0034, 0, "or_clr");
        issue(3'd3, 16'h8000, 16'h0001, 1, "sub_ovf");

        // Randomized traffic, including illegal codes and backpressure.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                  $urandom_range(0, 2), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
